// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// branch_predict_unit : direct-mapped BHT/BTB lookup (IF) and branch resolution (EX)
// Revision: 1.0
// ============================================================================
module branch_predict_unit #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [63:0]       if_pc,
  output logic              pred_taken,
  output logic [63:0]       pred_target,
  input  logic              ex_valid,
  input  logic [63:0]       ex_pc,
  input  logic [3:0]        ex_br_taken,
  input  logic [63:0]       ex_target,
  input  logic              ex_pred_taken,
  input  logic [63:0]       ex_pred_target,
  output logic              mispredict,
  output logic [63:0]       redirect_pc,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  mispred_count
);

  localparam int ENTRIES = 1 << INDEX_W;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [63:0]        target_q [ENTRIES];
  logic [63:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [CNT_W-1:0]   br_count_q, br_count_d;
  logic [CNT_W-1:0]   mispred_count_q, mispred_count_d;

  logic [INDEX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]   if_tag, ex_tag;
  logic               if_hit, ex_hit;
  logic               is_br, act;
  logic [2:0]         ex_op;

  assign if_idx = if_pc[INDEX_W+1:2];
  assign if_tag = if_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign ex_idx = ex_pc[INDEX_W+1:2];
  assign ex_tag = ex_pc[INDEX_W+TAG_W+1:INDEX_W+2];

  // Lookup sees only pre-edge table contents; no same-cycle bypass.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + 64'd4);

  assign ex_op  = ex_br_taken[2:0];
  assign is_br  = ex_valid && (ex_op != 3'd0) && (ex_op != 3'd7);
  assign act    = ex_br_taken[3] && is_br;
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // A stale taken prediction on a non-branch is flushed by the decoder, not here.
  assign mispredict  = is_br && ((act != ex_pred_taken) ||
                                 (act && ex_pred_taken && (ex_target != ex_pred_target)));
  assign redirect_pc = act ? ex_target : (ex_pc + 64'd4);

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

  always_comb begin
    valid_d         = valid_q;
    tag_d           = tag_q;
    target_d        = target_q;
    ctr_d           = ctr_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (is_br) begin
      if (ex_hit) begin
        if (act) begin
          target_d[ex_idx] = ex_target;
          if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'b01;
        end else if (ctr_q[ex_idx] != 2'b00) begin
          ctr_d[ex_idx] = ctr_q[ex_idx] - 2'b01;
        end
      end else if (act) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        ctr_d[ex_idx]    = 2'b10;
      end
      if (br_count_q != {CNT_W{1'b1}}) br_count_d = br_count_q + 1'b1;
      if (mispredict && (mispred_count_q != {CNT_W{1'b1}}))
        mispred_count_d = mispred_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q         <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q         <= valid_d;
      tag_q           <= tag_d;
      target_q        <= target_d;
      ctr_q           <= ctr_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  // PC bits outside index/tag and the byte offset do not participate.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[63:INDEX_W+TAG_W+2], if_pc[1:0],
                            ex_pc[63:INDEX_W+TAG_W+2], ex_pc[1:0]};

endmodule
`default_nettype wire

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Dynamic branch predictor and resolution unit for the 64-bit RV pipeline.
- IF stage: combinationally looks up a direct-mapped BHT/BTB and supplies the predicted next PC.
- EX stage: consumes the 4-bit branch-comparator result {taken, op[2:0]}, detects mispredictions, produces the redirect PC and updates the table on the clock edge.
- Also keeps saturating performance counters.

Parameters:
- INDEX_W, 4, log2 of table entries (16 entries); index = pc[INDEX_W+1:2]
- TAG_W, 8, tag bits; tag = pc[INDEX_W+TAG_W+1:INDEX_W+2]
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- if_pc  in  64  fetch PC
- pred_taken  out  1  prediction for if_pc
- pred_target  out  64  predicted next PC
- ex_valid  in  1  EX holds a live instruction (low on stall or flush)
- ex_pc  in  64  PC of the EX instruction
- ex_br_taken  in  4  comparator result: [3] = taken, [2:0] = branch op
- ex_target  in  64  computed branch target (pc+imm)
- ex_pred_taken  in  1  prediction piped from IF with this instruction
- ex_pred_target  in  64  predicted target piped from IF
- mispredict  out  1  redirect required this cycle
- redirect_pc  out  64  correct next PC when mispredict=1
- br_count  out  CNT_W  resolved conditional branches
- mispred_count  out  CNT_W  mispredicted branches

Behaviour:
- Reset is asynchronous, active-low, and asserts immediately:
  - every entry: valid=0, ctr=2'b01 (weakly not-taken), tag=0, target=0
  - br_count=0, mispred_count=0
  - combinational outputs follow from the cleared state: pred_taken=0, pred_target=if_pc+4
- Entry format: valid, tag[TAG_W], target[64], ctr[2].
- Lookup (combinational, zero latency):
  - hit = valid[idx] and tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = ex-free lookup: stored target if pred_taken, else if_pc+4 (64-bit wrap).
  - Lookup reads pre-edge state only; there is no bypass from a same-cycle update to the same index.
- Resolution (combinational):
  - is_br = ex_valid & (ex_br_taken[2:0] in 1..6); op 0 and op 7 are non-branches.
  - act = ex_br_taken[3] & is_br.
  - mispredict = is_br & ((act != ex_pred_taken) | (act & ex_pred_taken & ex_target != ex_pred_target)).
  - redirect_pc = act ? ex_target : ex_pc+4, driven whenever is_br; ex_pc+4 otherwise.
  - Non-branch with ex_pred_taken=1 (stale alias): no mispredict from this unit; the decoder owns that flush.
- Update (rising edge, only when is_br; EX index/tag taken from ex_pc):
  - Hit: ctr saturating +1 if act, -1 if not; stays at 3 or 0 at the limits. If act, target <= ex_target.
  - Miss and act: allocate, overwriting any victim: valid=1, tag, target=ex_target, ctr=2'b10.
  - Miss and not act: no change.
- Counters (when is_br):
  - br_count increments; mispred_count increments if mispredict.
  - Both saturate at all-ones and never wrap.
- ex_valid=0: no update, no counting, mispredict=0.
- Reset asserted mid-update: reset wins; no partial write survives.

Test Plan:
- Reset: rstn=0 then 1; if_pc=0x1000 -> pred_taken=0, pred_target=0x1004, both counters 0.
- Cold taken branch: ex_pc=0x1000, ex_br_taken=4'b1001, ex_target=0x0F00, ex_pred_taken=0
  - mispredict=1, redirect_pc=0x0F00
  - next cycle if_pc=0x1000 -> pred_taken=1, pred_target=0x0F00
  - br_count=1, mispred_count=1
- Hysteresis: repeat the same branch taken, then 4'b0001 (not taken) once with ex_pred_taken=1
  - mispredict=1, redirect_pc=0x1004
  - ctr 3->2, still predicts taken
  - a second not-taken makes it predict not-taken
- Target change: hit entry predicts 0x0F00 while ex_target=0x0E00 with act=1
  - mispredict=1, redirect_pc=0x0E00
  - subsequent lookup yields 0x0E00
- Aliasing and ops: 0x1000 allocated; taken branch at 0x1000+(1<<(INDEX_W+2)) evicts it
  - 0x1000 lookup then misses
  - ex_br_taken=4'b1000 or 4'b1111 -> no update, no count, mispredict=0
- Saturation and stall:
  - preload counters near all-ones -> they stop at all-ones
  - ex_valid=0 with a branch op present -> table and counters unchanged
  - async rstn pulse between edges clears state without a clock
